ultrasonic_ranger: RTL

- Parametrised HC-SR04 ranging controller.
- Generates periodic trigger pulses, measures echo width in microseconds with a synchronised edge-based FSM, and detects no-echo/overrange timeouts.
- Applies a power-of-two moving-average filter and maps the averaged distance onto LEVELS uniform intensity bins.
- Sits between the sensor pins and the intensity consumer; successor to the fixed 40 MHz / 8-level / 7-tap distance block.

---
 rtl/ultrasonic_ranger_if.sv | 33 +++
 rtl/ultrasonic_ranger.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if: sensor-side and consumer-side signals of the ranging controller
// master drives en/echo and observes results; slave is the controller.
//   en           ranging enable
//   echo         raw sensor echo pin (asynchronous)
//   trig         sensor trigger pin
//   sample_valid one-cycle pulse when echo_us/timeout update
//   echo_us      latest raw measurement in us, saturated at MAX_US+1
//   timeout      latest period produced no complete echo
//   avg_us       moving average of echo_us
//   intensity    0 = far/none, LEVELS = closest
interface ultrasonic_ranger_if #(
  parameter int MAX_US = 3552,
  parameter int LEVELS = 8
) ();
  localparam int UW = $clog2(MAX_US + 2);
  localparam int IW = $clog2(LEVELS + 1);
  logic          en;
  logic          echo;
  logic          trig;
  logic          sample_valid;
  logic [UW-1:0] echo_us;
  logic          timeout;
  logic [UW-1:0] avg_us;
  logic [IW-1:0] intensity;
  modport master (
    output en, echo,
    input  trig, sample_valid, echo_us, timeout, avg_us, intensity
  );
  modport slave (
    input  en, echo,
    output trig, sample_valid, echo_us, timeout, avg_us, intensity
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo controller with moving average and intensity binning
// clk   system clock, CLK_HZ
// reset asynchronous active-low reset
// bus   ultrasonic_ranger_if.slave: en/echo in; trig, sample_valid, echo_us, timeout, avg_us, intensity out
module ultrasonic_ranger #(
  parameter int CLK_HZ    = 40000000,
  parameter int TRIG_US   = 20,
  parameter int PERIOD_US = 60000,
  parameter int MAX_US    = 3552,
  parameter int LEVELS    = 8,
  parameter int AVG_LOG2  = 3
) (
  input logic clk,
  input logic reset,
  ultrasonic_ranger_if.slave bus
);
  localparam int DIV = CLK_HZ / 1000000;
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(PERIOD_US);
  localparam int UW  = $clog2(MAX_US + 2);
  localparam int IW  = $clog2(LEVELS + 1);
  localparam int N   = 1 << AVG_LOG2;
  localparam int AW  = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int SW  = UW + AVG_LOG2;
  localparam logic [UW-1:0] SAT       = UW'(MAX_US + 1);
  localparam logic [UW-1:0] BIN       = UW'(MAX_US / LEVELS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [PW-1:0] TRIG_LAST = PW'(TRIG_US - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_US - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(N - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] per_q, per_d;
  logic [UW-1:0] cnt_q, cnt_d;
  logic [UW-1:0] echo_us_q, echo_us_d;
  logic          timeout_q, timeout_d;
  logic          sv_q, sv_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [UW-1:0] ring_q [N];
  logic [UW-1:0] ring_d [N];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [UW-1:0] avg_q, avg_d;
  logic [IW-1:0] lvl_q, lvl_d;
  logic [UW-1:0] quo;
  logic          echo_s, rise, fall, tick, per_end;

  // sync_q[0..1] is the two-flop synchroniser; sync_q[2] holds the previous
  // synchronised level so edges are seen only on the clean signal.
  always_comb begin
    sync_d  = {sync_q[1:0], bus.echo};
    echo_s  = sync_q[1];
    rise    = sync_q[1] & ~sync_q[2];
    fall    = ~sync_q[1] & sync_q[2];
    tick    = div_q == DIV_LAST;
    per_end = tick && per_q == PER_LAST;
  end

  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    per_d     = '0;
    cnt_d     = cnt_q;
    echo_us_d = echo_us_q;
    timeout_d = timeout_q;
    sv_d      = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (bus.en) state_d = TRIG;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      per_d = per_end ? '0 : per_q + PW'(tick);
      // Period end outranks any edge seen in the same cycle.
      if (per_end) begin
        echo_us_d = state_q == HOLD ? cnt_q : SAT;
        timeout_d = state_q == WAIT_RISE || state_q == MEASURE;
        sv_d      = 1'b1;
        cnt_d     = '0;
        state_d   = bus.en ? TRIG : IDLE;
      end else if (state_q == TRIG && tick && per_q == TRIG_LAST) begin
        state_d = WAIT_RISE;
      end else if (state_q == WAIT_RISE && rise) begin
        state_d = MEASURE;
        cnt_d   = '0;
      end else if (state_q == MEASURE && fall) begin
        state_d = HOLD;
      end else if (state_q == MEASURE && tick && echo_s && cnt_q != SAT) begin
        cnt_d = cnt_q + UW'(1);
      end
    end
  end

  // The running sum replaces the oldest ring entry with the new sample, so the
  // average never needs a full re-summation.
  always_comb begin
    ring_d = ring_q;
    sum_d  = sum_q;
    ptr_d  = ptr_q;
    avg_d  = avg_q;
    lvl_d  = lvl_q;
    quo    = '0;
    if (sv_q) begin
      ring_d[ptr_q] = echo_us_q;
      sum_d = sum_q - SW'(ring_q[ptr_q]) + SW'(echo_us_q);
      ptr_d = ptr_q == PTR_LAST ? '0 : ptr_q + AW'(1);
      avg_d = UW'(sum_d >> AVG_LOG2);
      // Subtracting one makes each bin's upper edge inclusive.
      quo   = (avg_d - UW'(1)) / BIN;
      lvl_d = (avg_d == '0 || avg_d >= SAT) ? '0 : IW'(LEVELS) - IW'(quo);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      div_q     <= '0;
      per_q     <= '0;
      cnt_q     <= '0;
      echo_us_q <= '0;
      timeout_q <= 1'b0;
      sv_q      <= 1'b0;
      sum_q     <= SW'(N * (MAX_US + 1));
      for (int i = 0; i < N; i++) ring_q[i] <= SAT;
      ptr_q     <= '0;
      avg_q     <= SAT;
      lvl_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      div_q     <= div_d;
      per_q     <= per_d;
      cnt_q     <= cnt_d;
      echo_us_q <= echo_us_d;
      timeout_q <= timeout_d;
      sv_q      <= sv_d;
      sum_q     <= sum_d;
      ring_q    <= ring_d;
      ptr_q     <= ptr_d;
      avg_q     <= avg_d;
      lvl_q     <= lvl_d;
    end
  end

  assign bus.trig         = state_q == TRIG;
  assign bus.sample_valid = sv_q;
  assign bus.echo_us      = echo_us_q;
  assign bus.timeout      = timeout_q;
  assign bus.avg_us       = avg_q;
  assign bus.intensity    = lvl_q;
endmodule
